cmos_frame_gate: RTL and testbench

- Frame-aligned capture gate on the Boson pixel-clock domain. Sits between the CMOS input buffers and stream_upsizer.
- Passes only whole frames of 16-bit pixels into a valid/ready stream, and only while armed.
- Counts pixels and lines per frame and reports frame completion.
- Flags pixels lost to downstream back-pressure. The camera cannot be stalled, so the block never back-pressures the sensor.

---
 rtl/cmos_pkg.sv | 8 +
 rtl/cmos_gate_obuf.sv | 54 +++++
 rtl/cmos_frame_gate.sv | 123 ++++++++++++
 tb/tb_cmos_frame_gate.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_pkg.sv
// cmos_pkg: shared state encoding and default widths for the CMOS frame gate
package cmos_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;
  localparam int DEF_DW = 16;
  localparam int DEF_PIX_W = 24;
  localparam int DEF_LINE_W = 12;
  localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/cmos_gate_obuf.sv
// cmos_gate_obuf: registered output buffer, 1 entry, or a 4-entry FIFO when CMOS_FRAME_GATE_SKID_EN is defined
module cmos_gate_obuf #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          drop
);
  logic drain;
  assign drain = out_valid & out_ready;
`ifdef CMOS_FRAME_GATE_SKID_EN
  logic [DW-1:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] cnt;
  logic push;
  assign out_valid = cnt != 3'd0;
  assign out_data = mem[rp];
  assign drop = in_valid & (cnt == 3'd4) & ~drain;
  assign push = in_valid & ~drop;
  always_ff @(posedge clk)
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= in_data;
        wp <= wp + 2'd1;
      end
      if (drain) rp <= rp + 2'd1;
      cnt <= cnt + 3'(push) - 3'(drain);
    end
`else
  logic [DW-1:0] data;
  logic full;
  assign out_valid = full;
  assign out_data = data;
  assign drop = in_valid & full & ~out_ready;
  always_ff @(posedge clk)
    if (!resetn) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (in_valid & ~drop) data <= in_data;
      full <= (in_valid & ~drop) | (full & ~drain);
    end
`endif
endmodule

// File: rtl/cmos_frame_gate.sv
// cmos_frame_gate: armed whole-frame capture gate with counters and drop tracking; CMOS_FRAME_GATE_SKID_EN deepens the output buffer
module cmos_frame_gate import cmos_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int PIX_W = DEF_PIX_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int FRAME_PIXELS = 0,
  parameter int VSYNC_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  arm_i,
  input  logic                  single_i,
  input  logic [DW-1:0]         s_data_i,
  input  logic                  s_valid_i,
  input  logic                  s_vsync_i,
  input  logic                  s_hsync_i,
  output logic [DW-1:0]         m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [PIX_W-1:0]      last_pixels_o,
  output logic [LINE_W-1:0]     last_lines_o,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_count_o
);
  state_t state, state_nxt;
  logic vs_act, vs_q, hs_q, arm_q;
  logic vs_edge, hs_edge, arm_rise, cont;
  logic accept, done, drop, clr;
  logic [PIX_W-1:0] pix_cnt, pix_nxt, pix_step, pix_start, done_pix;
  logic [LINE_W-1:0] line_cnt, line_nxt, line_step, line_start, done_lines;
  assign vs_act = (VSYNC_ACT_LOW != 0) ? ~s_vsync_i : s_vsync_i;
  assign vs_edge = vs_act & ~vs_q;
  assign hs_edge = s_hsync_i & ~hs_q;
  assign arm_rise = arm_i & ~arm_q;
  assign cont = arm_i & ~single_i;
  assign busy_o = state != IDLE;
  assign clr = (state == IDLE) & arm_rise;
  assign pix_step = (s_valid_i && !(&pix_cnt)) ? pix_cnt + 1'b1 : pix_cnt;
  assign line_step = (hs_edge && !(&line_cnt)) ? line_cnt + 1'b1 : line_cnt;
  // A new frame's first cycle may already carry pixel 0 and a line start
  assign pix_start = PIX_W'(s_valid_i);
  assign line_start = LINE_W'(hs_edge);
  always_ff @(posedge clk) begin
    vs_q <= vs_act;
    hs_q <= s_hsync_i;
    arm_q <= arm_i;
  end
  always_comb begin
    state_nxt = state;
    pix_nxt = pix_cnt;
    line_nxt = line_cnt;
    accept = 1'b0;
    done = 1'b0;
    done_pix = pix_cnt;
    done_lines = line_cnt;
    case (state)
      IDLE: state_nxt = (arm_rise || cont) ? WAIT_VS : IDLE;
      WAIT_VS: if (vs_edge) begin
        state_nxt = ACTIVE;
        accept = s_valid_i;
        pix_nxt = pix_start;
        line_nxt = line_start;
      end
      ACTIVE: if (vs_edge) begin
        done = 1'b1;
        state_nxt = cont ? ACTIVE : IDLE;
        accept = cont & s_valid_i;
        pix_nxt = pix_start;
        line_nxt = line_start;
      end else begin
        accept = s_valid_i;
        pix_nxt = pix_step;
        line_nxt = line_step;
        if (FRAME_PIXELS != 0 && s_valid_i && pix_step == PIX_W'(FRAME_PIXELS)) begin
          done = 1'b1;
          done_pix = pix_step;
          done_lines = line_step;
          state_nxt = cont ? WAIT_VS : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      state <= IDLE;
      pix_cnt <= '0;
      line_cnt <= '0;
      frame_done_o <= 1'b0;
      last_pixels_o <= '0;
      last_lines_o <= '0;
      overflow_o <= 1'b0;
      drop_count_o <= '0;
    end else begin
      state <= state_nxt;
      pix_cnt <= pix_nxt;
      line_cnt <= line_nxt;
      frame_done_o <= done;
      if (done) begin
        last_pixels_o <= done_pix;
        last_lines_o <= done_lines;
      end
      if (clr) begin
        overflow_o <= 1'b0;
        drop_count_o <= '0;
      end else if (drop) begin
        overflow_o <= 1'b1;
        drop_count_o <= drop_count_o + DROP_CNT_W'(~&drop_count_o);
      end
    end
  cmos_gate_obuf #(.DW(DW)) u_obuf (
    .clk(clk),
    .resetn(resetn),
    .in_valid(accept),
    .in_data(s_data_i),
    .out_data(m_data_o),
    .out_valid(m_valid_o),
    .out_ready(m_ready_i),
    .drop(drop)
  );
endmodule

// File: tb/tb_cmos_frame_gate.sv
// tb_cmos_frame_gate: directed frame scenarios with random pixel data against a frame-level expectation model
module tb_cmos_frame_gate;
`ifdef CMOS_FRAME_GATE_SKID_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic clk = 1'b0, resetn = 1'b0, arm_i = 1'b0, arm_fp = 1'b0, single_i = 1'b1;
  logic [15:0] s_data_i = '0;
  logic s_valid_i = 1'b0, s_vsync_i = 1'b1, s_hsync_i = 1'b0, m_ready_i = 1'b1;
  logic [15:0] m_data_o, f_data;
  logic m_valid_o, busy_o, frame_done_o, overflow_o;
  logic f_valid, f_busy, f_done, f_overflow;
  logic [23:0] last_pixels_o, f_pixels;
  logic [11:0] last_lines_o, f_lines;
  logic [15:0] drop_count_o, f_drops;
  int ncmp = 0, nfail = 0, cyc = 0;
  int n_done = 0, n_exp = 0, fp_done = 0, fp_done_cyc = -1, fp_exp_cyc = -2, fp_left = 0;
  bit chk_lat = 1'b1;
  logic [15:0] q_d[$], fq[$];
  int q_c[$], ep[$], el[$];

  cmos_frame_gate dut (
    .clk(clk), .resetn(resetn), .arm_i(arm_i), .single_i(single_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_vsync_i(s_vsync_i), .s_hsync_i(s_hsync_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .last_pixels_o(last_pixels_o), .last_lines_o(last_lines_o),
    .overflow_o(overflow_o), .drop_count_o(drop_count_o)
  );
  cmos_frame_gate #(.FRAME_PIXELS(6)) dut_fp (
    .clk(clk), .resetn(resetn), .arm_i(arm_fp), .single_i(single_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_vsync_i(s_vsync_i), .s_hsync_i(s_hsync_i),
    .m_data_o(f_data), .m_valid_o(f_valid), .m_ready_i(m_ready_i), .busy_o(f_busy),
    .frame_done_o(f_done), .last_pixels_o(f_pixels), .last_lines_o(f_lines),
    .overflow_o(f_overflow), .drop_count_o(f_drops)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid_o && m_ready_i) begin
      chk("beat_pending", 32'(q_d.size() > 0), 32'd1);
      if (q_d.size() > 0) begin
        chk("beat_data", 32'(m_data_o), 32'(q_d.pop_front()));
        if (chk_lat) chk("beat_latency", 32'(cyc), 32'(q_c.pop_front()));
        else void'(q_c.pop_front());
      end
    end
    if (frame_done_o) begin
      n_done++;
      chk("done_expected", 32'(ep.size() > 0), 32'd1);
      if (ep.size() > 0) begin
        chk("last_pixels", 32'(last_pixels_o), 32'(ep.pop_front()));
        chk("last_lines", 32'(last_lines_o), 32'(el.pop_front()));
      end
    end
    if (f_valid && m_ready_i) begin
      chk("fp_beat_pending", 32'(fq.size() > 0), 32'd1);
      if (fq.size() > 0) chk("fp_beat_data", 32'(f_data), 32'(fq.pop_front()));
    end
    if (f_done) begin
      fp_done++;
      fp_done_cyc = cyc;
    end
  end

  task automatic drv(input bit v, input bit hs, input bit vs, input logic [15:0] d);
    @(posedge clk);
    #1;
    s_valid_i = v;
    s_hsync_i = hs;
    s_vsync_i = ~vs;
    s_data_i = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  // Records where a driven beat must reappear: main stream when captured, FRAME_PIXELS instance for its first beats
  task automatic put(input bit v, input bit cap, input logic [15:0] d);
    if (v && cap) begin
      q_d.push_back(d);
      q_c.push_back(cyc + 1);
    end
    if (v && fp_left > 0) begin
      fq.push_back(d);
      fp_left--;
      if (fp_left == 0) fp_exp_cyc = cyc + 1;
    end
  endtask

  task automatic frame(input bit vsbeat, input int lines, input int ppl, input bit cap, input bit bub);
    logic [15:0] d;
    d = 16'($urandom);
    drv(vsbeat, 1'b0, 1'b1, d);
    put(vsbeat, cap, d);
    drv(1'b0, 1'b0, 1'b1, 16'h0);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        if (bub && $urandom_range(2) == 0) drv(1'b0, 1'b1, 1'b0, 16'h0);
        d = 16'($urandom);
        drv(1'b1, 1'b1, 1'b0, d);
        put(1'b1, cap, d);
      end
      idle(2);
    end
    if (cap) begin
      ep.push_back(int'(vsbeat) + lines * ppl);
      el.push_back(lines);
      n_exp++;
    end
  endtask

  initial begin
    logic [15:0] d, first;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 32'(m_valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(frame_done_o), 32'd0);
    chk("rst_last_pixels", 32'(last_pixels_o), 32'd0);
    chk("rst_last_lines", 32'(last_lines_o), 32'd0);
    chk("rst_overflow", 32'(overflow_o), 32'd0);
    chk("rst_drop_count", 32'(drop_count_o), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    idle(2);
    // single 4x3 frame
    arm_i = 1'b1;
    idle(2);
    chk("t1_busy_armed", 32'(busy_o), 32'd1);
    frame(1'b0, 3, 4, 1'b1, 1'b0);
    frame(1'b0, 0, 0, 1'b0, 1'b0);
    idle(3);
    chk("t1_done_count", 32'(n_done), 32'(n_exp));
    chk("t1_idle", 32'(busy_o), 32'd0);
    chk("t1_drained", 32'(q_d.size()), 32'd0);
    arm_i = 1'b0;
    idle(2);
    // arm rising mid-frame waits for the next frame start
    frame(1'b0, 1, 4, 1'b0, 1'b0);
    arm_i = 1'b1;
    for (int p = 0; p < 4; p++) drv(1'b1, 1'b1, 1'b0, 16'($urandom));
    idle(2);
    frame(1'b0, 3, 4, 1'b1, 1'b1);
    frame(1'b0, 0, 0, 1'b0, 1'b0);
    idle(3);
    chk("t2_done_count", 32'(n_done), 32'(n_exp));
    chk("t2_idle", 32'(busy_o), 32'd0);
    arm_i = 1'b0;
    idle(2);
    // continuous capture of three back-to-back frames, then disarm
    single_i = 1'b0;
    arm_i = 1'b1;
    idle(2);
    for (int f = 0; f < 3; f++) frame(1'b1, 2 + f, 3 + f, 1'b1, 1'b1);
    arm_i = 1'b0;
    frame(1'b1, 0, 0, 1'b0, 1'b0);
    idle(3);
    chk("t3_done_count", 32'(n_done), 32'(n_exp));
    chk("t3_idle", 32'(busy_o), 32'd0);
    chk("t3_drained", 32'(q_d.size()), 32'd0);
    // back-pressure while five pixels arrive
    single_i = 1'b1;
    chk_lat = 1'b0;
    m_ready_i = 1'b0;
    arm_i = 1'b1;
    idle(2);
    drv(1'b0, 1'b0, 1'b1, 16'h0);
    drv(1'b0, 1'b0, 1'b1, 16'h0);
    first = '0;
    for (int i = 0; i < 5; i++) begin
      d = 16'($urandom);
      if (i == 0) first = d;
      drv(1'b1, 1'b1, 1'b0, d);
      if (i < DEPTH) put(1'b1, 1'b1, d);
    end
    idle(2);
    @(negedge clk);
    chk("t4_overflow", 32'(overflow_o), 32'd1);
    chk("t4_drop_count", 32'(drop_count_o), 32'(5 - DEPTH));
    chk("t4_held_valid", 32'(m_valid_o), 32'd1);
    chk("t4_held_data", 32'(m_data_o), 32'(first));
    m_ready_i = 1'b1;
    ep.push_back(5);
    el.push_back(1);
    n_exp++;
    frame(1'b0, 0, 0, 1'b0, 1'b0);
    idle(6);
    chk("t4_done_count", 32'(n_done), 32'(n_exp));
    chk("t4_drained", 32'(q_d.size()), 32'd0);
    arm_i = 1'b0;
    chk_lat = 1'b1;
    idle(2);
    // FRAME_PIXELS = 6 instance on a 12-pixel frame
    arm_fp = 1'b1;
    idle(2);
    fp_left = 6;
    frame(1'b0, 3, 4, 1'b0, 1'b0);
    frame(1'b0, 0, 0, 1'b0, 1'b0);
    idle(3);
    chk("t5_fp_done_count", 32'(fp_done), 32'd1);
    chk("t5_fp_done_cycle", 32'(fp_done_cyc), 32'(fp_exp_cyc));
    chk("t5_fp_pixels", 32'(f_pixels), 32'd6);
    chk("t5_fp_lines", 32'(f_lines), 32'd2);
    chk("t5_fp_drained", 32'(fq.size()), 32'd0);
    chk("t5_fp_idle", 32'(f_busy), 32'd0);
    arm_fp = 1'b0;
    idle(2);
    // reset in the middle of a captured frame
    arm_i = 1'b1;
    idle(2);
    chk("t6_overflow_cleared", 32'(overflow_o), 32'd0);
    chk("t6_drops_cleared", 32'(drop_count_o), 32'd0);
    drv(1'b0, 1'b0, 1'b1, 16'h0);
    drv(1'b0, 1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 2; i++) begin
      d = 16'($urandom);
      drv(1'b1, 1'b1, 1'b0, d);
      put(1'b1, 1'b1, d);
    end
    @(posedge clk);
    #1;
    resetn = 1'b0;
    s_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_m_valid", 32'(m_valid_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_done", 32'(frame_done_o), 32'd0);
    chk("t6_last_pixels", 32'(last_pixels_o), 32'd0);
    chk("t6_last_lines", 32'(last_lines_o), 32'd0);
    arm_i = 1'b0;
    idle(2);
    resetn = 1'b1;
    idle(2);
    frame(1'b0, 0, 0, 1'b0, 1'b0);
    idle(3);
    chk("t6_done_count", 32'(n_done), 32'(n_exp));
    chk("final_beats_drained", 32'(q_d.size()), 32'd0);
    chk("final_frames_drained", 32'(ep.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
